// File: rtl/dsp_bus_master_pkg.sv
// Shared constants for the DSP request-to-Wishbone bus master.
package dsp_bus_master_pkg;

  // Controller state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Data returned for a read that ends with an error or a timeout
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Bus-cycle timer width; TIMEOUT is limited to 65535
  localparam int unsigned TIMER_W = 16;

endpackage

// File: rtl/dsp_bus_master.sv
// Turns each accepted sequencer request into one Wishbone classic single
// cycle, with a bus timeout and sticky error capture.
module dsp_bus_master
  import dsp_bus_master_pkg::*;
#(
  parameter int unsigned     dw       = 32,
  parameter int unsigned     aw       = 32,
  parameter int unsigned     TIMEOUT  = 256,
  parameter logic [dw-1:0]   ERR_DATA = dw'(ERR_DATA_DEFAULT)
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          start,
  input  logic [aw-1:0] address,
  input  logic [3:0]    selection,
  input  logic          write,
  input  logic [dw-1:0] data_wr,
  output logic [dw-1:0] data_rd,
  output logic          active,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          error_clear,
  output logic          bus_error,
  output logic          bus_timeout,
  output logic [aw-1:0] error_address
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  logic [1:0]         state_q,   state_d;
  logic [TIMER_W-1:0] timer_q,   timer_d;
  logic               armed_q,   armed_d;
  logic [aw-1:0]      adr_q,     adr_d;
  logic [dw-1:0]      dat_q,     dat_d;
  logic [3:0]         sel_q,     sel_d;
  logic               we_q,      we_d;
  logic               cyc_q,     cyc_d;
  logic               active_q,  active_d;
  logic [dw-1:0]      rd_q,      rd_d;
  logic               berr_q,    berr_d;
  logic               btmo_q,    btmo_d;
  logic [aw-1:0]      eadr_q,    eadr_d;

  // State and output registers; reset drops the bus cycle immediately
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      armed_q  <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      active_q <= 1'b0;
      rd_q     <= '0;
      berr_q   <= 1'b0;
      btmo_q   <= 1'b0;
      eadr_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      armed_q  <= armed_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      cyc_q    <= cyc_d;
      active_q <= active_d;
      rd_q     <= rd_d;
      berr_q   <= berr_d;
      btmo_q   <= btmo_d;
      eadr_q   <= eadr_d;
    end
  end

  // Next-state: request acceptance, termination (err > ack > timeout), flags
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    armed_d  = armed_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    cyc_d    = cyc_q;
    active_d = active_q;
    rd_d     = rd_q;
    berr_d   = berr_q & ~error_clear;
    btmo_d   = btmo_q & ~error_clear;
    eadr_d   = eadr_q;

    // Re-arm only after start has been seen low, so a held start fires once
    if (!start) begin
      armed_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && armed_q) begin
          armed_d  = 1'b0;
          adr_d    = address;
          sel_d    = selection;
          we_d     = write;
          dat_d    = data_wr;
          cyc_d    = 1'b1;
          active_d = 1'b1;
          timer_d  = '0;
          state_d  = ST_BUS;
        end
      end
      ST_BUS: begin
        timer_d = timer_q + TIMER_W'(1);
        if (wb_err_i || wb_ack_i || (timer_q == TIMER_LAST)) begin
          cyc_d    = 1'b0;
          active_d = 1'b0;
          state_d  = ST_DONE;
          if (wb_err_i || !wb_ack_i) begin
            // Error or timeout: poison read data and capture the address
            if (!we_q) begin
              rd_d = ERR_DATA;
            end
            eadr_d = adr_q;
            if (wb_err_i) begin
              berr_d = 1'b1;
            end else begin
              btmo_d = 1'b1;
            end
          end else if (!we_q) begin
            rd_d = wb_dat_i;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        cyc_d    = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  assign data_rd       = rd_q;
  assign active        = active_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign wb_we_o       = we_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign bus_error     = berr_q;
  assign bus_timeout   = btmo_q;
  assign error_address = eadr_q;

endmodule

// File: tb/tb_dsp_bus_master.sv
// Directed bench for dsp_bus_master with a read-data scoreboard.
module tb_dsp_bus_master;

  logic        wb_clk;
  logic        wb_rst;
  logic        start;
  logic [31:0] address;
  logic [3:0]  selection;
  logic        write;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        active;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        error_clear;
  logic        bus_error;
  logic        bus_timeout;
  logic [31:0] error_address;

  int compared;
  int mismatched;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  int cyc_cnt;

  dsp_bus_master #(
    .dw(32), .aw(32), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .address(address),
    .selection(selection), .write(write), .data_wr(data_wr),
    .data_rd(data_rd), .active(active), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .error_clear(error_clear),
    .bus_error(bus_error), .bus_timeout(bus_timeout),
    .error_address(error_address)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge wb_clk);
  endtask

  task automatic pop_rd(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, data_rd, e);
      last_rd = e;
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] s, input logic w, input logic [31:0] d);
    address   = a;
    selection = s;
    write     = w;
    data_wr   = d;
    start     = 1'b1;
  endtask

  initial begin
    compared = 0; mismatched = 0; last_rd = '0;
    start = 0; address = '0; selection = '0; write = 0; data_wr = '0;
    wb_dat_i = '0; wb_ack_i = 0; wb_err_i = 0; error_clear = 0;
    wb_rst = 1'b0;
    #1 wb_rst = 1'b1;
    #2;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_data_rd", data_rd, 32'd0);
    chk("rst_flags", {30'd0, bus_error, bus_timeout}, 32'd0);
    tick();
    wb_rst = 1'b0;
    tick(); tick();

    // Write, slave acks in the 3rd bus cycle
    req(32'h40, 4'hF, 1'b1, 32'h1234_5678);
    tick();
    start = 0; address = 32'hFFFF_FFFF; data_wr = '0; write = 0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_active", 32'(active), 32'd1);
      chk("wr_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
      chk("wr_we", 32'(wb_we_o), 32'd1);
      chk("wr_adr", wb_adr_o, 32'h40);
      chk("wr_dat", wb_dat_o, 32'h1234_5678);
      if (i == 2) wb_ack_i = 1'b1;
      tick();
    end
    chk("wr_done_active", 32'(active), 32'd0);
    chk("wr_done_cyc", 32'(wb_cyc_o), 32'd0);
    chk("wr_data_rd", data_rd, last_rd);
    chk("wr_flags", {30'd0, bus_error, bus_timeout}, 32'd0);
    wb_ack_i = 0;
    tick(); tick();

    // Read, immediate ack
    req(32'h44, 4'hC, 1'b0, 32'h0);
    tick();
    chk("rd_active", 32'(active), 32'd1);
    chk("rd_sel", 32'(wb_sel_o), 32'hC);
    chk("rd_we", 32'(wb_we_o), 32'd0);
    start = 0; wb_ack_i = 1; wb_dat_i = 32'hCAFE_0000;
    exp_q.push_back(32'hCAFE_0000);
    tick();
    chk("rd_active_fall", 32'(active), 32'd0);
    pop_rd("rd_data");
    wb_ack_i = 0;
    tick(); tick();

    // Start held 5 cycles with ack held: only one bus cycle
    req(32'h48, 4'hF, 1'b0, 32'h0);
    wb_ack_i = 1; wb_dat_i = 32'h1111_2222;
    exp_q.push_back(32'h1111_2222);
    cyc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wb_cyc_o) cyc_cnt++;
      if (i == 1) pop_rd("held_rd_data");
    end
    chk("held_cyc_count", 32'(cyc_cnt), 32'd1);
    start = 0;
    tick();
    wb_dat_i = 32'h3333_4444;
    exp_q.push_back(32'h3333_4444);
    start = 1;
    tick();
    chk("rearm_cyc", 32'(wb_cyc_o), 32'd1);
    start = 0;
    tick();
    chk("rearm_active", 32'(active), 32'd0);
    pop_rd("rearm_rd_data");
    wb_ack_i = 0;
    tick(); tick();

    // Error and ack in the same cycle: error wins
    req(32'h80, 4'hF, 1'b0, 32'h0);
    tick();
    chk("err_cyc", 32'(wb_cyc_o), 32'd1);
    start = 0; wb_err_i = 1; wb_ack_i = 1; wb_dat_i = 32'h5555_5555;
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    chk("err_active", 32'(active), 32'd0);
    pop_rd("err_rd_data");
    chk("err_flag", 32'(bus_error), 32'd1);
    chk("err_tmo_flag", 32'(bus_timeout), 32'd0);
    chk("err_address", error_address, 32'h80);
    wb_err_i = 0; wb_ack_i = 0; error_clear = 1;
    tick();
    chk("err_cleared", 32'(bus_error), 32'd0);
    chk("err_addr_kept", error_address, 32'h80);
    error_clear = 0;
    tick();

    // Silent slave: timeout after 8 bus cycles
    req(32'h90, 4'hF, 1'b0, 32'h0);
    exp_q.push_back(32'hDEAD_BEEF);
    cyc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) start = 0;
      if (wb_cyc_o && wb_stb_o) cyc_cnt++;
      else break;
    end
    chk("tmo_cyc_count", 32'(cyc_cnt), 32'd8);
    chk("tmo_active", 32'(active), 32'd0);
    pop_rd("tmo_rd_data");
    chk("tmo_flag", 32'(bus_timeout), 32'd1);
    chk("tmo_err_flag", 32'(bus_error), 32'd0);
    chk("tmo_address", error_address, 32'h90);
    tick(); tick();

    // Asynchronous reset in the middle of a bus cycle
    req(32'hA0, 4'hF, 1'b1, 32'hAAAA_5555);
    tick();
    chk("arst_cyc_before", 32'(wb_cyc_o), 32'd1);
    start = 0;
    #2 wb_rst = 1'b1;
    #1;
    chk("arst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("arst_active", 32'(active), 32'd0);
    tick();
    wb_rst = 1'b0;
    last_rd = '0;
    wb_ack_i = 1; wb_dat_i = 32'h7777_7777;
    tick();
    chk("arst_late_ack_cyc", 32'(wb_cyc_o), 32'd0);
    chk("arst_late_ack_rd", data_rd, last_rd);
    chk("arst_flags", {30'd0, bus_error, bus_timeout}, 32'd0);
    chk("arst_err_addr", error_address, 32'd0);
    wb_ack_i = 0;
    tick();
    req(32'hB0, 4'h3, 1'b0, 32'h0);
    tick();
    chk("post_rst_cyc", 32'(wb_cyc_o), 32'd1);
    chk("post_rst_adr", wb_adr_o, 32'hB0);
    start = 0; wb_ack_i = 1; wb_dat_i = 32'h0BAD_F00D;
    exp_q.push_back(32'h0BAD_F00D);
    tick();
    chk("post_rst_active", 32'(active), 32'd0);
    pop_rd("post_rst_rd_data");
    wb_ack_i = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dsp_bus_master.md
Name: dsp_bus_master

Overview:
Responder end of the DSP state machine's memory-request handshake (start/address/selection/write/data_wr in, active/data_rd out). It converts each accepted request into one Wishbone classic single cycle on the system bus to WB_RAM0 and returns read data. It adds a bus timeout and error capture, so a hung or erroring slave cannot stall the DSP sequencer.

Parameters:
dw, 32, data width of request and Wishbone data buses
aw, 32, address width
TIMEOUT, 256, maximum cycles in BUS state before forced termination; legal range 2..65535
ERR_DATA, 32'hDEAD_BEEF, value returned on data_rd for a read terminated by error or timeout

Ports:
wb_clk  in  1  clock
wb_rst  in  1  asynchronous, active-high reset
start  in  1  request strobe from sequencer, level held until active is seen
address  in  aw  request byte address
selection  in  4  byte lane enables
write  in  1  1 = write, 0 = read
data_wr  in  dw  write data
data_rd  out  dw  read data, valid from the first cycle active is low after a read
active  out  1  high while a request is in flight
wb_adr_o  out  aw  Wishbone address
wb_dat_o  out  dw  Wishbone write data
wb_sel_o  out  4  Wishbone byte select
wb_we_o  out  1  Wishbone write enable
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_dat_i  in  dw  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
wb_err_i  in  1  Wishbone error
error_clear  in  1  clears the sticky error flags
bus_error  out  1  sticky: a transfer ended with wb_err_i
bus_timeout  out  1  sticky: a transfer ended by timeout
error_address  out  aw  wb_adr_o of the most recent errored or timed-out transfer

Behaviour:
- Reset (asynchronous, wb_rst=1): all outputs are 0, state=IDLE, timer=0, armed=0.
- armed flag: set on any edge where start==0; cleared when a request is accepted. A request is accepted only if armed, so a start held high across a completion never re-triggers.
- IDLE: if start && armed, at the edge:
  - Register wb_adr_o=address, wb_sel_o=selection, wb_we_o=write, wb_dat_o=data_wr.
  - Set wb_cyc_o=wb_stb_o=1 and active=1; clear timer; go to BUS.
  - Request inputs are sampled only at acceptance; later changes are ignored.
- BUS: cyc/stb/adr/sel/we/dat held stable; timer increments each cycle. Termination priority is err > ack > timeout.
  - wb_err_i: drop cyc/stb/active. data_rd=ERR_DATA if read (unchanged if write). bus_error=1, error_address=wb_adr_o. Go to DONE.
  - wb_ack_i (no err): drop cyc/stb/active. data_rd=wb_dat_i if read; unchanged on write. Go to DONE.
  - timer==TIMEOUT-1 with neither: same as err, but sets bus_timeout instead of bus_error.
- DONE: exactly one cycle, active=0, no bus activity, then IDLE. A new request is accepted at the earliest in IDLE, so consecutive transfers are separated by at least 2 idle bus cycles.
- Latency: ack in the first BUS cycle gives active high for exactly 1 cycle. data_rd is valid on the cycle active falls and holds until the next read completes.
- wb_ack_i/wb_err_i outside BUS are ignored.
- error_clear: clears bus_error and bus_timeout. A new error in the same cycle wins (flag stays 1). error_address is never cleared except by reset.
- Reset mid-transfer: cyc/stb/active drop immediately (asynchronously); the transfer is abandoned with no completion.
- timer width: 16 bits; no wrap possible within the legal TIMEOUT range.

Decomposition:
- State encodings (IDLE=2'd0, BUS=2'd1, DONE=2'd2) and the ERR_DATA default go in dsp_includes.vh beside the existing file/status offsets.
- Single module; the timeout counter is small enough to stay inline, so no sub-module.

Test Plan:
- Write 0x1234_5678 to 0x0000_0040, sel=F; slave acks on the 3rd BUS cycle -> wb_we_o=1, wb_adr_o=0x40, wb_dat_o=0x12345678 stable for 3 cycles; active high 3 cycles; data_rd unchanged; no flags.
- Read from 0x44, sel=0xC; slave acks immediately with wb_dat_i=0xCAFE_0000 -> active high exactly 1 cycle; data_rd=0xCAFE0000 the cycle active falls.
- Start held high for 5 cycles across a 1-cycle transfer -> exactly one Wishbone cycle; second request only after start has been sampled low.
- Read with wb_err_i and wb_ack_i in the same cycle at 0x80 -> data_rd=0xDEADBEEF, bus_error=1, error_address=0x80; error_clear pulse -> bus_error=0.
- TIMEOUT=8, slave never responds to a read -> cyc/stb high exactly 8 cycles, then data_rd=0xDEADBEEF, bus_timeout=1, active falls.
- Assert wb_rst during BUS -> cyc/stb/active go 0 without waiting for a clock edge; a later ack is ignored; the next request proceeds normally.
